// File: rtl/mp3_vga_timing_if.sv
`default_nettype none
// ============================================================================
//  Module      : mp3_vga_timing_if
//  Description : Bundle between the pixel timing generator and the display
//                renderer.
//                Signals: i_pix_en (pixel-rate enable into the generator);
//                o_x/o_y (signed coordinates); o_hs/o_vs (sync);
//                o_de (data enable); o_line/o_frame (1-clk strobes);
//                o_frame_cnt (completed-frame counter).
//                The master modport is the generator. The slave modport is
//                the consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mp3_vga_timing_if;
  logic               i_pix_en;
  logic signed [15:0] o_x;
  logic signed [15:0] o_y;
  logic               o_hs;
  logic               o_vs;
  logic               o_de;
  logic               o_line;
  logic               o_frame;
  logic [15:0]        o_frame_cnt;

  modport master (
    input  i_pix_en,
    output o_x, o_y, o_hs, o_vs, o_de, o_line, o_frame, o_frame_cnt
  );

  modport slave (
    output i_pix_en,
    input  o_x, o_y, o_hs, o_vs, o_de, o_line, o_frame, o_frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mp3_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : mp3_vga_timing
//  Description : Pixel timing generator for the MP3 player display renderer.
//                It produces signed screen coordinates. Blanking pixels and
//                lines use negative coordinates. It also produces sync pulses,
//                data-enable, line/frame strobes and a completed-frame counter.
//                All outputs are registered.
//                Ports: clk, rst (synchronous, active-high).
//                The vif port uses the master modport:
//                  i_pix_en (in);
//                  o_x, o_y, o_hs, o_vs, o_de, o_line, o_frame,
//                  o_frame_cnt (out).
//  Revision    : 1.0 - initial release
// ============================================================================
module mp3_vga_timing #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  mp3_vga_timing_if.master      vif
);

  // Coordinates start at minus the total blanking width. As a result, the
  // active area begins exactly at zero.
  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;

  localparam logic signed [15:0] H_STA   = 16'(-H_BLANK);
  localparam logic signed [15:0] V_STA   = 16'(-V_BLANK);
  localparam logic signed [15:0] H_LAST  = 16'(H_RES - 1);
  localparam logic signed [15:0] V_LAST  = 16'(V_RES - 1);
  localparam logic signed [15:0] H_ACT   = 16'(H_RES);
  localparam logic signed [15:0] V_ACT   = 16'(V_RES);
  localparam logic signed [15:0] HS_BEG  = 16'(H_FP - H_BLANK);
  localparam logic signed [15:0] HS_END  = 16'(H_FP + H_SYNC - H_BLANK);
  localparam logic signed [15:0] VS_BEG  = 16'(V_FP - V_BLANK);
  localparam logic signed [15:0] VS_END  = 16'(V_FP + V_SYNC - V_BLANK);
  localparam logic signed [15:0] ZERO    = 16'sd0;

  logic signed [15:0] x_cur, y_cur;
  logic signed [15:0] x_next, y_next;
  logic               line_next, frame_next;
  logic [15:0]        cnt_cur, cnt_next;
  logic               hs_cur, vs_cur, de_cur, line_cur, frame_cur;
  logic               hs_next, vs_next, de_next;

  // Next-state coordinates. The sync and de signals are decoded from the
  // next coordinates. They are registered together with those coordinates,
  // so they never lag the coordinates.
  always_comb begin
    x_next     = x_cur;
    y_next     = y_cur;
    cnt_next   = cnt_cur;
    line_next  = 1'b0;
    frame_next = 1'b0;
    if (vif.i_pix_en) begin
      if (x_cur == H_LAST) begin
        x_next    = H_STA;
        line_next = 1'b1;
        if (y_cur == V_LAST) begin
          y_next     = V_STA;
          frame_next = 1'b1;
          cnt_next   = cnt_cur + 16'd1;
        end else begin
          y_next = y_cur + 16'sd1;
        end
      end else begin
        x_next = x_cur + 16'sd1;
      end
    end
  end

  always_comb begin
    hs_next = ((x_next >= HS_BEG) && (x_next < HS_END)) ? H_POL : ~H_POL;
    vs_next = ((y_next >= VS_BEG) && (y_next < VS_END)) ? V_POL : ~V_POL;
    de_next = (x_next >= ZERO) && (x_next < H_ACT) &&
              (y_next >= ZERO) && (y_next < V_ACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cur     <= H_STA;
      y_cur     <= V_STA;
      hs_cur    <= ~H_POL;
      vs_cur    <= ~V_POL;
      de_cur    <= 1'b0;
      line_cur  <= 1'b0;
      frame_cur <= 1'b0;
      cnt_cur   <= 16'd0;
    end else begin
      x_cur     <= x_next;
      y_cur     <= y_next;
      hs_cur    <= hs_next;
      vs_cur    <= vs_next;
      de_cur    <= de_next;
      line_cur  <= line_next;
      frame_cur <= frame_next;
      cnt_cur   <= cnt_next;
    end
  end

  assign vif.o_x         = x_cur;
  assign vif.o_y         = y_cur;
  assign vif.o_hs        = hs_cur;
  assign vif.o_vs        = vs_cur;
  assign vif.o_de        = de_cur;
  assign vif.o_line      = line_cur;
  assign vif.o_frame     = frame_cur;
  assign vif.o_frame_cnt = cnt_cur;

endmodule
`default_nettype wire

// File: tb/tb_mp3_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mp3_vga_timing
//  Description : Self-checking bench for mp3_vga_timing.
//                One instance uses the default 640x480 timing. Its first lines
//                are checked against literal expectations. A second instance
//                uses small timing parameters and is checked every cycle
//                against an arithmetic model. The model derives every output
//                from the number of enables seen since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mp3_vga_timing;

  // Small geometry for the model-checked instance
  localparam int S_H_RES = 8, S_H_FP = 2, S_H_SYNC = 3, S_H_BP = 2;
  localparam int S_V_RES = 4, S_V_FP = 1, S_V_SYNC = 2, S_V_BP = 1;
  localparam int HT  = S_H_RES + S_H_FP + S_H_SYNC + S_H_BP;   // 15
  localparam int VT  = S_V_RES + S_V_FP + S_V_SYNC + S_V_BP;   // 8
  localparam int FT  = HT * VT;                                // 120
  localparam int HST = -(S_H_FP + S_H_SYNC + S_H_BP);          // -7
  localparam int VST = -(S_V_FP + S_V_SYNC + S_V_BP);          // -4

  logic clk;
  logic d_rst, s_rst;
  logic chk_on;

  int n_chk  = 0;
  int n_fail = 0;

  mp3_vga_timing_if d_if ();
  mp3_vga_timing_if s_if ();

  mp3_vga_timing u_def (
    .clk (clk),
    .rst (d_rst),
    .vif (d_if.master)
  );

  mp3_vga_timing #(
    .H_RES(S_H_RES), .V_RES(S_V_RES),
    .H_FP(S_H_FP), .H_SYNC(S_H_SYNC), .H_BP(S_H_BP),
    .V_FP(S_V_FP), .V_SYNC(S_V_SYNC), .V_BP(S_V_BP),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_small (
    .clk (clk),
    .rst (s_rst),
    .vif (s_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (small instance) ----------------
  int n;          // enables since last reset
  bit m_line, m_frame;

  always @(posedge clk) begin
    if (s_rst) begin
      n       <= 0;
      m_line  <= 1'b0;
      m_frame <= 1'b0;
    end else if (s_if.i_pix_en) begin
      n       <= n + 1;
      m_line  <= ((n + 1) % HT) == 0;
      m_frame <= ((n + 1) % FT) == 0;
    end else begin
      m_line  <= 1'b0;
      m_frame <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int ex, ey, ecnt;
      bit ehs, evs, ede;
      ex   = HST + (n % HT);
      ey   = VST + ((n / HT) % VT);
      ecnt = (n / FT) % 65536;
      ehs  = !((ex >= HST + S_H_FP) && (ex < HST + S_H_FP + S_H_SYNC));
      evs  = !((ey >= VST + S_V_FP) && (ey < VST + S_V_FP + S_V_SYNC));
      ede  = (ex >= 0) && (ex < S_H_RES) && (ey >= 0) && (ey < S_V_RES);
      chk("m_x",     s_if.o_x,         ex);
      chk("m_y",     s_if.o_y,         ey);
      chk("m_hs",    s_if.o_hs,        ehs);
      chk("m_vs",    s_if.o_vs,        evs);
      chk("m_de",    s_if.o_de,        ede);
      chk("m_line",  s_if.o_line,      m_line);
      chk("m_frame", s_if.o_frame,     m_frame);
      chk("m_cnt",   s_if.o_frame_cnt, ecnt);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int first_line, nlines, de_seen, hs_low, hs_x;
    clk = 1'b0;
    d_rst = 1'b1; d_if.i_pix_en = 1'b0;
    s_rst = 1'b1; s_if.i_pix_en = 1'b0;
    chk_on = 1'b0;
    first_line = -1; nlines = 0; de_seen = 0; hs_low = 0; hs_x = 0;

    // Default geometry: first two lines after reset
    repeat (3) @(negedge clk);
    d_rst = 1'b0; d_if.i_pix_en = 1'b1;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("def_first_x",  d_if.o_x,  -159);
        chk("def_first_y",  d_if.o_y,  -45);
        chk("def_first_de", d_if.o_de, 0);
        chk("def_first_hs", d_if.o_hs, 1);
        chk("def_first_vs", d_if.o_vs, 1);
      end
      if (d_if.o_line) begin
        nlines++;
        if (first_line < 0) first_line = k;
      end
      if (d_if.o_de) de_seen++;
      if (k < 800 && !d_if.o_hs) begin
        if (hs_low == 0) hs_x = d_if.o_x;
        hs_low++;
      end
    end
    chk("def_first_line_clk", first_line, 800);
    chk("def_line_count",     nlines,     2);
    chk("def_hs_low_len",     hs_low,     96);
    chk("def_hs_start_x",     hs_x,       -144);
    chk("def_de_blank_lines", de_seen,    0);
    d_if.i_pix_en = 1'b0;

    // Small geometry: reset state
    chk_on = 1'b1;
    @(negedge clk);
    chk("s_rst_x",   s_if.o_x, -7);
    chk("s_rst_y",   s_if.o_y, -4);
    chk("s_rst_hs",  s_if.o_hs, 1);
    chk("s_rst_vs",  s_if.o_vs, 1);
    chk("s_rst_cnt", s_if.o_frame_cnt, 0);

    // Continuous enable for two frames
    s_rst = 1'b0; s_if.i_pix_en = 1'b1;
    for (int k = 1; k <= 240; k++) begin
      @(negedge clk);
      if (k == 1)   chk("s_first_x", s_if.o_x, -6);
      if (k == 15)  chk("s_first_line", s_if.o_line, 1);
      if (k == 120) begin
        chk("s_frame1_strobe", s_if.o_frame, 1);
        chk("s_frame1_line",   s_if.o_line, 1);
        chk("s_frame1_cnt",    s_if.o_frame_cnt, 1);
        chk("s_frame1_x",      s_if.o_x, -7);
        chk("s_frame1_y",      s_if.o_y, -4);
      end
      if (k == 121) chk("s_frame1_1clk", s_if.o_frame, 0);
      if (k == 240) chk("s_frame2_cnt", s_if.o_frame_cnt, 2);
    end

    // Enable 1-in-4
    for (int k = 0; k < 720; k++) begin
      s_if.i_pix_en = (k % 4) == 0;
      @(negedge clk);
    end

    // Random enable with occasional reset
    for (int k = 0; k < 3000; k++) begin
      s_if.i_pix_en = $urandom_range(0, 1) == 1;
      s_rst         = $urandom_range(0, 199) == 0;
      @(negedge clk);
    end

    // Reset in the middle of a frame
    s_rst = 1'b1; s_if.i_pix_en = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("s_mid_x", s_if.o_x, 3);
    chk("s_mid_y", s_if.o_y, 2);
    s_rst = 1'b1;
    @(negedge clk);
    chk("s_midrst_x",     s_if.o_x, -7);
    chk("s_midrst_y",     s_if.o_y, -4);
    chk("s_midrst_cnt",   s_if.o_frame_cnt, 0);
    chk("s_midrst_line",  s_if.o_line, 0);
    chk("s_midrst_frame", s_if.o_frame, 0);
    s_rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
